// File: rtl/tx_arb_pkg.sv
// Shared types and default constants for the UART transmit arbiter.
// TX_ARB_GAP_EN adds the post-message GAP state.
package tx_arb_pkg;

    localparam int N_REQ_DEF      = 4;
    localparam int GAP_CYCLES_DEF = 15000;

`ifdef TX_ARB_GAP_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        ACK  = 2'd2,
        GAP  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        ACK  = 2'd2
    } state_t;
`endif

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches from the index after
// ptr (last winner), wrapping, and returns a one-hot winner.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding whole messages from N_REQ byte sources
// to one UART transmitter. Define TX_ARB_GAP_EN for the idle gap.
module uart_tx_arbiter
    import tx_arb_pkg::*;
#(
    parameter int N_REQ      = N_REQ_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*8-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ack,
    output logic [N_REQ-1:0]   grant,
    output logic [7:0]         word,
    output logic               connection_status,
    input  logic               transmit_ready,
    output logic               busy
);

    localparam int PW = $clog2(N_REQ);

    state_t           state, state_n;
    logic [N_REQ-1:0] grant_n, win;
    logic [PW-1:0]    ptr, ptr_n, win_idx;
    logic             last_q, last_n;
    logic             sel_valid, sel_last, take;
    logic [7:0]       sel_data;

`ifdef TX_ARB_GAP_EN
    localparam int CW = (GAP_CYCLES > 0) ?
                        $clog2(GAP_CYCLES + 1) : 1;
    logic [CW-1:0] cnt, cnt_n;
`endif

    rr_arbiter #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr (
        .req (req_valid),
        .ptr (ptr),
        .win (win)
    );

    always_comb begin
        sel_data  = 8'h00;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_data  = req_data[8*i +: 8];
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
            end
            if (win[i]) begin
                win_idx = PW'(i);
            end
        end
    end

    assign busy              = (state != IDLE);
    assign connection_status = (state == SEND) && sel_valid;
    assign word              = (state == SEND) ? sel_data : 8'h00;
    assign req_ack           = (state == ACK) ? grant : '0;
    assign take              = connection_status && transmit_ready;

    // Pointer resets to the top index so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= '0;
            ptr    <= PW'(N_REQ - 1);
            last_q <= 1'b0;
        end else begin
            state  <= state_n;
            grant  <= grant_n;
            ptr    <= ptr_n;
            last_q <= last_n;
        end
    end

`ifdef TX_ARB_GAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_n;
        end
    end
`endif

    always_comb begin
        state_n = state;
        grant_n = grant;
        ptr_n   = ptr;
        last_n  = last_q;
`ifdef TX_ARB_GAP_EN
        cnt_n   = cnt;
`endif
        unique case (state)
            IDLE: begin
                if (|req_valid) begin
                    grant_n = win;
                    ptr_n   = win_idx;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (take) begin
                    last_n  = sel_last;
                    state_n = ACK;
                end
            end
            ACK: begin
                if (last_q) begin
                    grant_n = '0;
`ifdef TX_ARB_GAP_EN
                    if (GAP_CYCLES > 0) begin
                        cnt_n   = CW'(GAP_CYCLES);
                        state_n = GAP;
                    end else begin
                        state_n = IDLE;
                    end
`else
                    state_n = IDLE;
`endif
                end else begin
                    state_n = SEND;
                end
            end
`ifdef TX_ARB_GAP_EN
            GAP: begin
                cnt_n = cnt - CW'(1);
                if (cnt <= CW'(1)) begin
                    state_n = IDLE;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: round-robin message model,
// random ready/valid stalls, reset and late-arrival scenarios.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int GAP = 5;
`ifdef TX_ARB_GAP_EN
    localparam int EXP_GAP = GAP;
`else
    localparam int EXP_GAP = 0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_last, req_ack, grant;
    logic [N*8-1:0] req_data;
    logic [7:0]     word;
    logic           connection_status, transmit_ready, busy;

    uart_tx_arbiter #(
        .N_REQ      (N),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_data          (req_data),
        .req_last          (req_last),
        .req_ack           (req_ack),
        .grant             (grant),
        .word              (word),
        .connection_status (connection_status),
        .transmit_ready    (transmit_ready),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t       sb[$];
    logic [8:0] rq[N][$];
    int         drop_cnt[N];
    int         nm[N];
    logic [N-1:0] pend = '0;
    bit         rnd_tr = 0, rnd_drop = 0;
    int         cmp_n = 0, err_n = 0;
    int         mptr;

    for (genvar g = 0; g < N; g++) begin : g_valid
        assign req_valid[g] = pend[g] &&
                              !(drop_cnt[g] != 0 && grant[g]);
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: actual 0x%0h required 0x%0h",
                     name, act, exp);
        end
    endtask

    task automatic add_byte(input int i, input logic [7:0] d,
                            input logic l);
        exp_t e;
        e.idx  = i;
        e.data = d;
        e.last = l;
        rq[i].push_back({l, d});
        sb.push_back(e);
        mptr = i;
    endtask

    // Reference: whole messages, visiting requesters round-robin
    // starting after the last winner.
    task automatic plan(input int maxlen);
        int  rem[N];
        int  len, pick;
        for (int i = 0; i < N; i++) rem[i] = nm[i];
        forever begin
            pick = -1;
            for (int off = 1; off <= N; off++) begin
                if (pick < 0 && rem[(mptr + off) % N] > 0)
                    pick = (mptr + off) % N;
            end
            if (pick < 0) break;
            len = $urandom_range(1, maxlen);
            for (int b = 0; b < len; b++)
                add_byte(pick, 8'($urandom), b == len - 1);
            rem[pick]--;
        end
    endtask

    // Requester behaviour and transmitter backpressure.
    initial for (int i = 0; i < N; i++) drop_cnt[i] = 0;
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (req_ack[i] && rq[i].size() > 0)
                void'(rq[i].pop_front());
            if (drop_cnt[i] > 0)
                drop_cnt[i]--;
            else if (rnd_drop && $urandom_range(0, 7) == 0)
                drop_cnt[i] = $urandom_range(1, 4);
            pend[i] = rq[i].size() > 0;
            req_data[8*i +: 8] = pend[i] ? rq[i][0][7:0] : 8'h00;
            req_last[i] = pend[i] ? rq[i][0][8] : 1'b0;
        end
        transmit_ready = rnd_tr ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    bit           ack_due = 0, last_due = 0, counting = 0;
    logic [N-1:0] exp_ack;
    int           gcnt;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            ack_due  = 0;
            counting = 0;
        end else begin
            if (counting) begin
                if (busy && grant == '0 && gcnt < 1000) begin
                    gcnt++;
                end else begin
                    chk("gap_len", 32'(gcnt), 32'(EXP_GAP));
                    chk("idle_busy", 32'(busy), 32'(0));
                    counting = 0;
                end
            end
            if (ack_due) begin
                chk("req_ack", 32'(req_ack), 32'(exp_ack));
                ack_due = 0;
                if (last_due) begin
                    counting = 1;
                    gcnt     = 0;
                end
            end else if (req_ack != '0) begin
                chk("stray_ack", 32'(req_ack), 32'(0));
            end
            if (grant != '0 && (grant & req_valid) == '0)
                chk("hold_conn", 32'(connection_status), 32'(0));
            if (connection_status && transmit_ready) begin
                if (sb.size() == 0) begin
                    chk("extra_byte", 32'(word), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("word", 32'(word), 32'(e.data));
                    chk("grant", 32'(grant), 32'(1) << e.idx);
                    exp_ack  = N'(1) << e.idx;
                    last_due = e.last;
                    ack_due  = 1;
                end
            end
        end
    end

    task automatic wait_done(input int maxc);
        int c = 0;
        while ((sb.size() != 0 || ack_due || counting) && c < maxc) begin
            @(posedge clk);
            c++;
        end
        if (c >= maxc) begin
            cmp_n++;
            err_n++;
            $display("FAIL timeout: %0d bytes still expected", sb.size());
            sb.delete();
            for (int i = 0; i < N; i++) rq[i].delete();
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_conn"}, 32'(connection_status), 32'(0));
        chk({tag, "_word"}, 32'(word), 32'(0));
        chk({tag, "_ack"}, 32'(req_ack), 32'(0));
    endtask

    initial begin
        int c;
        mptr           = N - 1;
        rst            = 1'b1;
        transmit_ready = 1'b1;
        req_data       = '0;
        req_last       = '0;
        repeat (3) @(negedge clk);
        check_quiet("rst");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        add_byte(0, 8'h61, 1'b0);
        add_byte(0, 8'h62, 1'b0);
        add_byte(0, 8'h63, 1'b1);
        wait_done(300);
        chk("abc_grant_clear", 32'(grant), 32'(0));

        for (int b = 0; b < 6; b++)
            add_byte(2, 8'(8'h30 + b), b == 5);
        c = 0;
        while (rq[2].size() > 4 && c < 300) begin
            @(posedge clk);
            c++;
        end
        #2 rst = 1'b1;
        #1 check_quiet("async_rst");
        sb.delete();
        for (int i = 0; i < N; i++) rq[i].delete();
        mptr = N - 1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);

        nm = '{2, 1, 1, 1};
        plan(1);
        wait_done(400);

        for (int b = 0; b < 4; b++)
            add_byte(2, 8'($urandom), b == 3);
        c = 0;
        while (rq[2].size() > 3 && c < 300) begin
            @(posedge clk);
            c++;
        end
        nm = '{1, 0, 0, 0};
        plan(2);
        wait_done(400);

        for (int b = 0; b < 3; b++)
            add_byte(0, 8'($urandom), b == 2);
        c = 0;
        while (rq[0].size() > 2 && c < 300) begin
            @(posedge clk);
            c++;
        end
        drop_cnt[0] = 10;
        wait_done(400);

        rnd_tr   = 1;
        rnd_drop = 1;
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < N; i++) nm[i] = $urandom_range(0, 2);
            plan(4);
            wait_done(3000);
        end
        rnd_tr   = 0;
        rnd_drop = 0;
        repeat (4) @(negedge clk);
        check_quiet("end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 cmp_n, err_n);
        $finish;
    end

endmodule
